// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access initiator between the CPU execute stage and data_memory.
// Accepts one load/store at a time over a valid/ready handshake, drives the
// data_memory byte-pair port, waits out its one-cycle registered read latency
// and returns a single-cycle completion pulse. Byte stores are implemented as
// read-modify-write: the partner byte at addr+1 is read back and rewritten
// unchanged.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : word access with addr[0]=1 is rejected (ERR state, rsp_err=1,
//               no memory enable asserted, rsp_rdata untouched)
//   undefined : misaligned words proceed as ordinary byte-pair accesses and
//               rsp_err is tied low
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready = idle and not in reset)
//   req_write           1 = store, 0 = load
//   req_byte            1 = byte access, 0 = 16-bit word
//   req_signed          byte load: sign-extend bit 7
//   req_addr/req_wdata  byte address / store data (byte store uses [7:0])
//   rsp_valid           one-cycle completion pulse (loads and stores)
//   rsp_rdata           load result, held until the next load completes
//   rsp_err             misalignment error, qualified by rsp_valid
//   mem_*               data_memory write_enable/read_enable/addr/data_in/data_out
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RMW_RD,
    S_RMW_WAIT,
    S_RMW_WR,
    S_DONE
`ifdef LSU_ALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        r_byte;
  logic        r_signed;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [7:0]  r_hi_byte;
  logic [15:0] r_rdata;

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_rdata = r_rdata;

`ifdef LSU_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_err;
  assign w_misaligned = !req_byte && req_addr[0];
  assign rsp_err      = (r_state == S_DONE) && r_err;
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte    <= 1'b0;
      r_signed  <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_hi_byte <= 8'h00;
      r_rdata   <= 16'h0000;
`ifdef LSU_ALIGN_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_byte   <= req_byte;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
`ifdef LSU_ALIGN_CHECK_EN
        r_err    <= w_misaligned;
`endif
      end
      // Read data is valid throughout the WAIT states because data_memory
      // registered the read at the preceding RD / RMW_RD edge.
      if (r_state == S_RD_WAIT) begin
        if (r_byte) begin
          r_rdata <= {{8{r_signed & mem_data_out[7]}}, mem_data_out[7:0]};
        end else begin
          r_rdata <= mem_data_out;
        end
      end
      if (r_state == S_RMW_WAIT) begin
        r_hi_byte <= mem_data_out[15:8];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next           = r_state;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = 16'h0000;
    mem_data_in      = 16'h0000;
    if (r_state != S_IDLE) begin
      mem_addr = r_addr;
    end
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
          if (w_misaligned)   w_next = S_ERR;
          else
`endif
          if (!req_write)     w_next = S_RD;
          else if (req_byte)  w_next = S_RMW_RD;
          else                w_next = S_WR;
        end
      end
      S_RD: begin
        mem_read_enable = 1'b1;
        w_next          = S_RD_WAIT;
      end
      S_RD_WAIT: w_next = S_DONE;
      S_WR: begin
        mem_write_enable = 1'b1;
        mem_data_in      = r_wdata;
        w_next           = S_DONE;
      end
      S_RMW_RD: begin
        mem_read_enable = 1'b1;
        w_next          = S_RMW_WAIT;
      end
      S_RMW_WAIT: w_next = S_RMW_WR;
      S_RMW_WR: begin
        mem_write_enable = 1'b1;
        mem_data_in      = {r_hi_byte, r_wdata[7:0]};
        w_next           = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
`ifdef LSU_ALIGN_CHECK_EN
      S_ERR: w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit with a behavioural data_memory model
// (byte-addressed, 16-bit byte-pair port, one-cycle registered read, address
// wrap at 0xFFFF). Reset image: 0xCD at 0x0000, 0x2B at 0x0001, 0x12 at
// 0x0003, 0x34 at 0x0004. Build with +define+LSU_ALIGN_CHECK_EN to cover the
// alignment-check variant.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_write_enable, mem_read_enable;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_byte         (req_byte),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  // Behavioural data_memory.
  logic [7:0]  mem [0:65535];
  logic [15:0] mem_addr_p1;
  assign mem_addr_p1 = mem_addr + 16'd1;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'hCD;
    mem[1] = 8'h2B;
    mem[3] = 8'h12;
    mem[4] = 8'h34;
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr]    <= mem_data_in[7:0];
      mem[mem_addr_p1] <= mem_data_in[15:8];
    end
    if (mem_read_enable) mem_data_out <= {mem[mem_addr_p1], mem[mem_addr]};
  end

  // Bus monitor: running totals sampled away from the active edge.
  int          cyc = 0, rd_tot = 0, wr_tot = 0, both_tot = 0, addr_bad = 0;
  int          last_rd_cyc = 0, last_wr_cyc = 0;
  logic [15:0] exp_addr = 16'h0000;

  always @(negedge clk) begin
    cyc++;
    if (mem_read_enable)  begin rd_tot++; last_rd_cyc = cyc; end
    if (mem_write_enable) begin wr_tot++; last_wr_cyc = cyc; end
    if (mem_read_enable && mem_write_enable) both_tot++;
    if ((mem_read_enable || mem_write_enable) && mem_addr !== exp_addr) addr_bad++;
  end

  // Issue one request, scramble the request fields after acceptance, and
  // return the accept-to-rsp_valid latency plus the response fields.
  task automatic issue(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic er,
                       output time acc_t);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = d; exp_addr = a;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_byte = ~b; req_signed = ~s;
    req_addr = 16'hAAAA; req_wdata = 16'h5A5A;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_checks++;
    if ({rsp_valid, rsp_err, mem_read_enable, mem_write_enable} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000", {rsp_valid, rsp_err, mem_read_enable, mem_write_enable});
    end
    n_checks++;
    if ({rsp_rdata, mem_addr, mem_data_in} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h din %h want 0", rsp_rdata, mem_addr, mem_data_in);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_load;
    int lat; logic [15:0] rd; logic er; time t; int rd0, wr0;
    rd0 = rd_tot; wr0 = wr_tot;
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, er, t);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL wload_latency: got %0d want 3", lat); end
    n_checks++;
    if (rd !== 16'h2BCD) begin n_fail++; $display("FAIL wload_data: got %h want 2bcd", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL wload_err: got %b want 0", er); end
    n_checks++;
    if (rd_tot - rd0 !== 1 || wr_tot - wr0 !== 0) begin
      n_fail++; $display("FAIL wload_enables: reads %0d writes %0d want 1 0", rd_tot - rd0, wr_tot - wr0);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wload_pulse_width: got %b want 0", rsp_valid); end
  endtask

  task automatic test_byte_load;
    int lat; logic [15:0] rd; logic er; time t;
    logic [15:0] exp_v [3] = '{16'hFFCD, 16'h00CD, 16'h002B};
    logic        sgn   [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] adr   [3] = '{16'h0000, 16'h0000, 16'h0001};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, sgn[i], adr[i], 16'h0000, lat, rd, er, t);
      n_checks++;
      if (lat !== 3 || rd !== exp_v[i]) begin
        n_fail++; $display("FAIL bload_%0d: got lat %0d data %h want 3 %h", i, lat, rd, exp_v[i]);
      end
    end
  endtask

  task automatic test_word_store;
    int lat; logic [15:0] rd; logic er; time t; int rd0, wr0;
    rd0 = rd_tot; wr0 = wr_tot;
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, lat, rd, er, t);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL wstore_latency: got %0d want 2", lat); end
    n_checks++;
    if (wr_tot - wr0 !== 1 || rd_tot - rd0 !== 0) begin
      n_fail++; $display("FAIL wstore_enables: writes %0d reads %0d want 1 0", wr_tot - wr0, rd_tot - rd0);
    end
    n_checks++;
    if (rd !== 16'h002B) begin n_fail++; $display("FAIL wstore_rdata_hold: got %h want 002b", rd); end
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, er, t);
    n_checks++;
    if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL wstore_readback: got %h want beef", rd); end
  endtask

  task automatic test_byte_store;
    int lat; logic [15:0] rd; logic er; time t; int rd0, wr0, b0;
    rd0 = rd_tot; wr0 = wr_tot; b0 = both_tot;
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h3355, lat, rd, er, t);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL bstore_latency: got %0d want 4", lat); end
    n_checks++;
    if (rd_tot - rd0 !== 1 || wr_tot - wr0 !== 1 || both_tot - b0 !== 0) begin
      n_fail++; $display("FAIL bstore_enables: reads %0d writes %0d overlap %0d want 1 1 0",
                         rd_tot - rd0, wr_tot - wr0, both_tot - b0);
    end
    n_checks++;
    if (!(last_rd_cyc < last_wr_cyc)) begin
      n_fail++; $display("FAIL bstore_order: read cyc %0d write cyc %0d want read first", last_rd_cyc, last_wr_cyc);
    end
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, er, t);
    n_checks++;
    if (rd !== 16'hBE55) begin n_fail++; $display("FAIL bstore_readback: got %h want be55", rd); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd; logic er; time t0, t1;
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, er, t0);
    issue(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, lat, rd, er, t1);
    n_checks++;
    if (t1 - t0 != 40) begin n_fail++; $display("FAIL b2b_accept_spacing: got %0t want 40", t1 - t0); end
    n_checks++;
    if (rd !== 16'h002B) begin n_fail++; $display("FAIL b2b_data: got %h want 002b", rd); end
  endtask

  task automatic test_reset_mid_rmw;
    int lat; logic [15:0] rd; logic er; time t; int wr0, n;
    wr0 = wr_tot;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'h0077; exp_addr = 16'h0010;
    @(posedge clk);
    @(negedge clk);           // RMW_RD
    req_valid = 1'b0;
    @(negedge clk);           // RMW_WAIT
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_read_enable, mem_write_enable} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_ctl: got %b want 00000",
                         {req_ready, rsp_valid, rsp_err, mem_read_enable, mem_write_enable});
    end
    n_checks++;
    if ({rsp_rdata, mem_addr, mem_data_in} !== 48'h0) begin
      n_fail++; $display("FAIL midrst_data: rdata %h addr %h din %h want 0", rsp_rdata, mem_addr, mem_data_in);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    n_checks++;
    if (wr_tot !== wr0) begin n_fail++; $display("FAIL midrst_no_write: writes %0d want 0", wr_tot - wr0); end
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, er, t);
    n_checks++;
    if (rd !== 16'hBE55) begin n_fail++; $display("FAIL midrst_readback: got %h want be55", rd); end
  endtask

  task automatic test_misaligned;
    int lat; logic [15:0] rd; logic er; time t; int rd0, wr0;
    rd0 = rd_tot; wr0 = wr_tot;
    issue(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, er, t);
`ifdef LSU_ALIGN_CHECK_EN
    n_checks++;
    if (lat !== 2 || er !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got lat %0d err %b want 2 1", lat, er); end
    n_checks++;
    if (rd_tot !== rd0 || wr_tot !== wr0) begin
      n_fail++; $display("FAIL misalign_enables: reads %0d writes %0d want 0 0", rd_tot - rd0, wr_tot - wr0);
    end
    n_checks++;
    if (rd !== 16'hBE55) begin n_fail++; $display("FAIL misalign_rdata_hold: got %h want be55", rd); end
`else
    n_checks++;
    if (lat !== 3 || er !== 1'b0) begin n_fail++; $display("FAIL misalign_ok: got lat %0d err %b want 3 0", lat, er); end
    n_checks++;
    if (rd !== 16'h3412) begin n_fail++; $display("FAIL misalign_data: got %h want 3412", rd); end
    n_checks++;
    if (rd_tot - rd0 !== 1 || wr_tot !== wr0) begin
      n_fail++; $display("FAIL misalign_enables: reads %0d writes %0d want 1 0", rd_tot - rd0, wr_tot - wr0);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    test_reset();
    test_word_load();
    test_byte_load();
    test_word_store();
    test_byte_store();
    test_back_to_back();
    test_reset_mid_rmw();
    test_misaligned();
    n_checks++;
    if (both_tot !== 0 || addr_bad !== 0) begin
      n_fail++; $display("FAIL bus_invariants: overlap %0d bad_addr %0d want 0 0", both_tot, addr_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
